// File: rtl/multicycle_control_if.sv
// Shared instruction/data memory port between the multi-cycle control unit and memory.
interface multicycle_control_if;
    logic MemReq;
    logic MemWrite;
    logic IorD;
    logic MemReady;

    modport master (output MemReq, output MemWrite, output IorD, input MemReady);
    modport slave  (input MemReq, input MemWrite, input IorD, output MemReady);
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the 16-bit 4-register CPU: FETCH/DECODE/EXECUTE/MEM/WRITEBACK/HALT,
// with memory wait timeout, sticky illegal/bus-error flags and a retired-instruction counter.
//
//   state      | meaning
//   FETCH      | request instruction at PC, load IR and PC+2 on MemReady
//   DECODE     | latch opcode, trap HALT and undefined opcodes
//   EXECUTE    | ALU operation, branch/jump PC update
//   MEM        | data access for LW/SW at ALU result
//   WRITEBACK  | register-file write
//   HALT       | idle until reset
module multicycle_control #(
    parameter logic [3:0] WAIT_MAX = 4'd15
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic [3:0]           Opcode,
    input  logic                 Zero,
    multicycle_control_if.master mem,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic [1:0]           PCSrc,
    output logic                 RegWrite,
    output logic                 RegDst,
    output logic                 MemToReg,
    output logic                 ALUSrcB,
    output logic [1:0]           ALUOp,
    output logic [2:0]           State,
    output logic                 Halted,
    output logic                 Illegal,
    output logic                 BusErr,
    output logic [15:0]          RetireCount
);
    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [3:0] OP_ADDI = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_BEQ  = 4'd7;
    localparam logic [3:0] OP_JMP  = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd15;

    state_t      state, state_nxt;
    logic [3:0]  op_q;
    logic [3:0]  wait_cnt, wait_nxt;
    logic        illegal_q, buserr_q;
    logic [15:0] retire_cnt;
    logic        retire, set_illegal, set_buserr, timeout;
    logic        mem_req, mem_write, iord;

    assign timeout = !mem.MemReady && (wait_cnt == WAIT_MAX);

    always_comb begin
        state_nxt   = state;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_buserr  = 1'b0;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCSrc       = 2'b00;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        MemToReg    = 1'b0;
        ALUSrcB     = 1'b0;
        ALUOp       = 2'b00;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem.MemReady) begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    state_nxt = S_DECODE;
                end else if (timeout) begin
                    set_buserr = 1'b1;
                    state_nxt  = S_HALT;
                end
            end
            S_DECODE: begin
                if (Opcode == OP_HALT) begin
                    retire    = 1'b1;
                    state_nxt = S_HALT;
                end else if (Opcode > OP_JMP) begin
                    set_illegal = 1'b1;
                    retire      = 1'b1;
                    state_nxt   = S_FETCH;
                end else begin
                    state_nxt = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                state_nxt = S_FETCH;
                if (op_q < OP_ADDI) begin
                    ALUOp     = op_q[1:0];
                    state_nxt = S_WRITEBACK;
                end else if (op_q == OP_ADDI) begin
                    ALUSrcB   = 1'b1;
                    state_nxt = S_WRITEBACK;
                end else if (op_q == OP_LW || op_q == OP_SW) begin
                    ALUSrcB   = 1'b1;
                    state_nxt = S_MEM;
                end else if (op_q == OP_BEQ) begin
                    ALUOp   = 2'b01;
                    PCSrc   = 2'b01;
                    PCWrite = Zero;
                    retire  = 1'b1;
                end else if (op_q == OP_JMP) begin
                    PCSrc   = 2'b10;
                    PCWrite = 1'b1;
                    retire  = 1'b1;
                end
            end
            S_MEM: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = (op_q == OP_SW);
                if (mem.MemReady) begin
                    if (op_q == OP_SW) begin
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_WRITEBACK;
                    end
                end else if (timeout) begin
                    set_buserr = 1'b1;
                    state_nxt  = S_HALT;
                end
            end
            S_WRITEBACK: begin
                RegWrite  = 1'b1;
                RegDst    = (op_q < OP_ADDI);
                MemToReg  = (op_q == OP_LW);
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
        // State sits at FETCH during reset; keep the bus and strobes quiet until release.
        if (!Reset_n) begin
            mem_req   = 1'b0;
            mem_write = 1'b0;
            iord      = 1'b0;
            IRWrite   = 1'b0;
            PCWrite   = 1'b0;
            PCSrc     = 2'b00;
            RegWrite  = 1'b0;
            RegDst    = 1'b0;
            MemToReg  = 1'b0;
            ALUSrcB   = 1'b0;
            ALUOp     = 2'b00;
        end
    end

    always_comb begin
        wait_nxt = 4'd0;
        if (state_nxt == state && !mem.MemReady && (state == S_FETCH || state == S_MEM))
            wait_nxt = wait_cnt + 4'd1;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= S_FETCH;
            op_q       <= 4'd0;
            wait_cnt   <= 4'd0;
            illegal_q  <= 1'b0;
            buserr_q   <= 1'b0;
            retire_cnt <= 16'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (state == S_DECODE) op_q <= Opcode;
            if (set_illegal) illegal_q <= 1'b1;
            if (set_buserr) buserr_q <= 1'b1;
            if (retire) retire_cnt <= retire_cnt + 16'd1;
        end
    end

    assign mem.MemReq   = mem_req;
    assign mem.MemWrite = mem_write;
    assign mem.IorD     = iord;
    assign State        = state;
    assign Halted       = (state == S_HALT);
    assign Illegal      = illegal_q;
    assign BusErr       = buserr_q;
    assign RetireCount  = retire_cnt;
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: an instruction-level model queues the expected
// per-cycle control word, and a negedge monitor pops and compares against the DUT.
module tb_multicycle_control;
    localparam logic [3:0] WAIT_MAX = 4'd15;

    typedef struct packed {
        logic        mem_req;
        logic        mem_write;
        logic        iord;
        logic        ir_write;
        logic        pc_write;
        logic [1:0]  pc_src;
        logic        reg_write;
        logic        reg_dst;
        logic        mem_to_reg;
        logic        alu_src_b;
        logic [1:0]  alu_op;
        logic [2:0]  state;
        logic        halted;
        logic        illegal;
        logic        bus_err;
        logic [15:0] retire;
    } ctl_t;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic [3:0]  Opcode;
    logic        Zero;
    logic        IRWrite, PCWrite, RegWrite, RegDst, MemToReg, ALUSrcB, Halted, Illegal, BusErr;
    logic [1:0]  PCSrc, ALUOp;
    logic [2:0]  State;
    logic [15:0] RetireCount;
    ctl_t        obs;

    multicycle_control_if bus();

    multicycle_control #(.WAIT_MAX(WAIT_MAX)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Opcode(Opcode), .Zero(Zero), .mem(bus),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemToReg(MemToReg), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .State(State), .Halted(Halted), .Illegal(Illegal), .BusErr(BusErr),
        .RetireCount(RetireCount)
    );

    always #5 Clock = ~Clock;

    assign obs = {bus.MemReq, bus.MemWrite, bus.IorD, IRWrite, PCWrite, PCSrc, RegWrite, RegDst,
                  MemToReg, ALUSrcB, ALUOp, State, Halted, Illegal, BusErr, RetireCount};

    int    n_cmp = 0;
    int    n_bad = 0;
    ctl_t  expq[$];
    string nameq[$];

    logic [15:0] m_retire;
    logic        m_illegal, m_buserr, m_halted;

    task automatic check(input ctl_t got, input ctl_t want, input string nm);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, got, want);
        end
    endtask

    always @(negedge Clock) begin
        if (expq.size() > 0) begin
            ctl_t  e;
            string nm;
            e  = expq.pop_front();
            nm = nameq.pop_front();
            check(obs, e, nm);
        end
    end

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rnd4();
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic ctl_t base(input logic [2:0] st);
        ctl_t e = '0;
        e.state   = st;
        e.halted  = (st == 3'd5);
        e.illegal = m_illegal;
        e.bus_err = m_buserr;
        e.retire  = m_retire;
        return e;
    endfunction

    // One clock of stimulus: drive inputs, queue the control word expected for this cycle.
    task automatic step(input ctl_t e, input string nm, input logic rdy, input logic [3:0] op,
                        input logic z);
        bus.MemReady = rdy;
        Opcode       = op;
        Zero         = z;
        expq.push_back(e);
        nameq.push_back(nm);
        @(posedge Clock);
        #1;
    endtask

    // Memory access lasting wt not-ready cycles; returns 0 if it timed out into HALT.
    task automatic mem_access(input logic [2:0] st, input logic wr, input int wt, input string nm,
                              output bit ok);
        ctl_t e;
        ok = 1'b0;
        for (int i = 0; i <= wt; i++) begin
            e = base(st);
            e.mem_req   = 1'b1;
            e.iord      = (st == 3'd3);
            e.mem_write = wr;
            if (i == wt) begin
                if (st == 3'd0) begin
                    e.ir_write = 1'b1;
                    e.pc_write = 1'b1;
                end
                step(e, nm, 1'b1, rnd4(), rbit());
                ok = 1'b1;
                return;
            end
            step(e, {nm, "_wait"}, 1'b0, rnd4(), rbit());
            if (i == int'(WAIT_MAX)) begin
                m_buserr = 1'b1;
                m_halted = 1'b1;
                return;
            end
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input logic z, input int wf, input int wm);
        ctl_t e;
        bit   ok;
        mem_access(3'd0, 1'b0, wf, "fetch", ok);
        if (!ok) return;
        step(base(3'd1), "decode", rbit(), op, rbit());
        if (op == 4'd15) begin
            m_retire++;
            m_halted = 1'b1;
            return;
        end
        if (op >= 4'd9) begin
            m_illegal = 1'b1;
            m_retire++;
            return;
        end
        e = base(3'd2);
        if (op == 4'd7) begin
            e.alu_op   = 2'b01;
            e.pc_src   = 2'b01;
            e.pc_write = z;
            step(e, "exec_beq", rbit(), rnd4(), z);
            m_retire++;
            return;
        end
        if (op == 4'd8) begin
            e.pc_src   = 2'b10;
            e.pc_write = 1'b1;
            step(e, "exec_jmp", rbit(), rnd4(), rbit());
            m_retire++;
            return;
        end
        if (op <= 4'd3) e.alu_op = op[1:0];
        else e.alu_src_b = 1'b1;
        step(e, "exec", rbit(), rnd4(), rbit());
        if (op == 4'd5 || op == 4'd6) begin
            mem_access(3'd3, op == 4'd6, wm, "mem", ok);
            if (!ok) return;
            if (op == 4'd6) begin
                m_retire++;
                return;
            end
        end
        e = base(3'd4);
        e.reg_write  = 1'b1;
        e.reg_dst    = (op <= 4'd3);
        e.mem_to_reg = (op == 4'd5);
        step(e, "writeback", rbit(), rnd4(), rbit());
        m_retire++;
    endtask

    // Sit in HALT for n+1 cycles, then pulse reset asynchronously in the middle of a cycle.
    task automatic halt_and_reset(input int n);
        repeat (n) step(base(3'd5), "halt", rbit(), rnd4(), rbit());
        bus.MemReady = rbit();
        expq.push_back(base(3'd5));
        nameq.push_back("halt_last");
        @(negedge Clock);
        #1;
        Reset_n      = 1'b0;
        bus.MemReady = 1'b0;
        #1;
        check(obs, ctl_t'('0), "async_reset");
        @(posedge Clock);
        #1;
        Reset_n   = 1'b1;
        m_retire  = 16'd0;
        m_illegal = 1'b0;
        m_buserr  = 1'b0;
        m_halted  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] op;
        int         r, wf, wm;
        Reset_n      = 1'b0;
        bus.MemReady = 1'b1;
        Opcode       = 4'd0;
        Zero         = 1'b0;
        m_retire     = 16'd0;
        m_illegal    = 1'b0;
        m_buserr     = 1'b0;
        m_halted     = 1'b0;
        #3;
        check(obs, ctl_t'('0), "reset_state");
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;

        run_instr(4'd0, 1'b0, 0, 0);
        run_instr(4'd5, 1'b0, 0, 3);
        run_instr(4'd7, 1'b1, 0, 0);
        run_instr(4'd7, 1'b0, 0, 0);
        run_instr(4'd10, 1'b0, 0, 0);
        run_instr(4'd1, 1'b0, 1, 0);
        run_instr(4'd2, 1'b0, 0, 0);
        run_instr(4'd3, 1'b0, 2, 0);
        run_instr(4'd4, 1'b0, 0, 0);
        run_instr(4'd6, 1'b0, 1, 2);
        run_instr(4'd8, 1'b0, 0, 0);
        run_instr(4'd0, 1'b0, 15, 0);
        run_instr(4'd5, 1'b0, 0, 15);
        run_instr(4'd0, 1'b0, 16, 0);
        halt_and_reset(2);
        run_instr(4'd15, 1'b0, 0, 0);
        halt_and_reset(3);
        run_instr(4'd5, 1'b0, 0, 16);
        halt_and_reset(1);

        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 99);
            if (r < 4) op = 4'd15;
            else if (r < 10) op = 4'($urandom_range(9, 14));
            else op = 4'($urandom_range(0, 8));
            wf = ($urandom_range(0, 99) < 3) ? 16 : $urandom_range(0, 3);
            wm = ($urandom_range(0, 99) < 3) ? 16 : $urandom_range(0, 3);
            run_instr(op, rbit(), wf, wm);
            if (m_halted) halt_and_reset($urandom_range(0, 3));
        end

        @(negedge Clock);
        #1;
        n_cmp++;
        if (expq.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
